decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter DWIDTH, default 32, instruction width in bits.
REQ-002 Parameter AWIDTH, default 32, PC width in bits.
REQ-003 Parameter BASEADDR, default 32'h01000000, PC value presented after reset.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port pc_i  input  AWIDTH  PC of the incoming instruction, from fetch.
REQ-007 Port insn_i  input  DWIDTH  incoming instruction word, from fetch.
REQ-008 Port valid_i  input  1  pc_i/insn_i carry a valid instruction.
REQ-009 Port ready_o  output  1  decode can accept an instruction this cycle.
REQ-010 Port flush_i  input  1  synchronous discard of all held instructions.
REQ-011 Port valid_o  output  1  decoded outputs are valid.
REQ-012 Port ready_i  input  1  downstream accepts the decoded instruction this cycle.
REQ-013 Port pc_o  output  AWIDTH  PC of the held instruction.
REQ-014 Port insn_o  output  DWIDTH  raw held instruction.
REQ-015 Ports opcode_o[6:0], rd_o[4:0], rs1_o[4:0], rs2_o[4:0], funct3_o[2:0], funct7_o[6:0]  output  RV32I fields sliced from insn_o.
REQ-016 Port imm_o  output  32  sign-extended immediate for the instruction format.
REQ-017 Port fmt_o  output  fmt_e  instruction format: R, I, S, B, U or J.
REQ-018 Port illegal_o  output  1  opcode outside the RV32I base set, or insn_o[1:0] != 2'b11.

Function
REQ-019 Storage: output register (OUT) plus one skid entry (SKID); FSM states EMPTY, ONE (OUT full), TWO (OUT and SKID full).
REQ-020 Input transfer when valid_i && ready_o; output transfer when valid_o && ready_i.
REQ-021 ready_o driven directly from a flop: 1 in EMPTY and ONE, 0 in TWO; never combinationally dependent on ready_i.
REQ-022 valid_o = 1 in ONE and TWO, 0 in EMPTY.
REQ-023 EMPTY + input -> ONE, input loaded into OUT.
REQ-024 ONE + input + output -> ONE, input loaded into OUT (full throughput, one instruction per cycle).
REQ-025 ONE + input, no output -> TWO, input loaded into SKID; OUT held.
REQ-026 ONE + output, no input -> EMPTY.
REQ-027 TWO + output -> ONE, SKID moves into OUT.
REQ-028 TWO, no output -> TWO, all held; pc_o/insn_o stable while valid_o && !ready_i.
REQ-029 flush_i has priority over every other event: next state EMPTY, input on the same cycle discarded, OUT contents retain values but valid_o = 0.
REQ-030 Latency: an instruction accepted at edge N appears on valid_o/pc_o/insn_o after edge N (one cycle).
REQ-031 Field, imm_o, fmt_o and illegal_o outputs are combinational from insn_o only.
REQ-032 Immediates: I = sext(insn[31:20]); S = sext({insn[31:25],insn[11:7]}); B = sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}); U = {insn[31:12],12'b0}; J = sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}); R = 0.
REQ-033 Format map: 0110011 R; 0010011/0000011/1100111/1110011 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; any other opcode sets illegal_o and drives fmt_o R, imm_o 0.
REQ-034 Decoded fields are only meaningful while valid_o = 1; a bench checks them only then.

Reset
REQ-035 While rst = 0: state EMPTY, valid_o 0, ready_o 0, pc_o BASEADDR, insn_o 32'h00000013 (NOP), SKID cleared.
REQ-036 After rst deasserts, ready_o rises on the first clk edge; no input is accepted while rst = 0.
REQ-037 Reset asserted mid-operation discards OUT and SKID immediately and asynchronously.

Structure
REQ-038 Shared package rv32i_pkg holds fmt_e, the opcode constants and the NOP constant; fetch and decode both import it.
REQ-039 Immediate and format logic is a sub-module imm_gen (insn in; imm, fmt, illegal out), purely combinational.

Verification
REQ-040 Reset, then valid_i=1, insn_i=32'h00500093, pc_i=32'h01000000, ready_i=1 -> next cycle valid_o=1, opcode 0x13, rd 1, rs1 0, imm_o 5, fmt I.
REQ-041 insn_i=32'h0020A423 -> fmt S, rs1 1, rs2 2, funct3 3'b010, imm_o 8; insn_i=32'hFE000EE3 -> fmt B, imm_o 32'hFFFFFFFC.
REQ-042 insn_i=32'h123452B7 -> fmt U, rd 5, imm_o 32'h12345000; insn_i=32'h010000EF -> fmt J, rd 1, imm_o 16.
REQ-043 Backpressure: stream PCs 0x01000000/04/08, ready_i=0 for 2 cycles -> ready_o=0 after two accepts, pc_o holds 0x01000000; ready_i=1 -> 0x01000000, 0x01000004, 0x01000008 in order, none lost or duplicated.
REQ-044 flush_i=1 in state TWO with valid_i=1 -> next cycle valid_o=0, ready_o=1; no flushed PC ever appears with valid_o=1.
REQ-045 insn_i=32'hFFFFFFFF -> illegal_o=1; reset asserted in TWO -> valid_o=0, pc_o=32'h01000000 without a clock edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I definitions shared by fetch and decode: instruction formats, base opcodes, canonical NOP.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I format classifier and immediate extractor.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] insn,
    output logic [31:0] imm,
    output fmt_e        fmt,
    output logic        illegal
);

    always_comb begin
        imm     = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (insn[6:0])
            OP_OP: fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = {{20{insn[31]}}, insn[31:20]};
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = {insn[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
        // Compressed encodings are not supported.
        if (insn[1:0] != 2'b11)
            illegal = 1'b1;
    end

endmodule

// File: rtl/decode.sv
// Decode stage: output register plus one skid entry so ready_o stays a pure flop output.
module decode
    import rv32i_pkg::*;
#(
    parameter int                 DWIDTH   = 32,
    parameter int                 AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  BASEADDR = AWIDTH'(32'h01000000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [31:0]       imm_o,
    output fmt_e              fmt_o,
    output logic              illegal_o
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

    state_e            state_q, state_n;
    logic              ready_q;
    logic [AWIDTH-1:0] skid_pc;
    logic [DWIDTH-1:0] skid_insn;
    logic              in_xfer, out_xfer;
    logic              load_out, load_skid, skid_to_out;

    assign valid_o  = (state_q != EMPTY);
    assign ready_o  = ready_q;
    assign in_xfer  = valid_i && ready_q;
    assign out_xfer = valid_o && ready_i;

    always_comb begin
        state_n     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush_i) begin
            state_n = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    state_n  = ONE;
                    load_out = 1'b1;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_out = 1'b1;
                    end else if (in_xfer) begin
                        state_n   = TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_n = EMPTY;
                    end
                end
                TWO: if (out_xfer) begin
                    state_n     = ONE;
                    skid_to_out = 1'b1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // ready_o is registered from the next state, so it never depends on ready_i combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            ready_q   <= 1'b0;
            pc_o      <= BASEADDR;
            insn_o    <= DWIDTH'(NOP);
            skid_pc   <= '0;
            skid_insn <= '0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n != TWO);
            if (load_out) begin
                pc_o   <= pc_i;
                insn_o <= insn_i;
            end else if (skid_to_out) begin
                pc_o   <= skid_pc;
                insn_o <= skid_insn;
            end
            if (load_skid) begin
                skid_pc   <= pc_i;
                skid_insn <= insn_i;
            end
        end
    end

    assign opcode_o = insn_o[6:0];
    assign rd_o     = insn_o[11:7];
    assign funct3_o = insn_o[14:12];
    assign rs1_o    = insn_o[19:15];
    assign rs2_o    = insn_o[24:20];
    assign funct7_o = insn_o[31:25];

    imm_gen u_imm_gen (
        .insn    (insn_o[31:0]),
        .imm     (imm_o),
        .fmt     (fmt_o),
        .illegal (illegal_o)
    );

endmodule

// File: tb/tb_decode.sv
// Decode stage bench: directed literal cases plus randomized traffic against a 2-deep queue model.
module tb_decode;
    import rv32i_pkg::*;

    localparam logic [31:0] BASE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0, insn_i = '0;
    logic        valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
    logic        ready_o, valid_o, illegal_o;
    logic [31:0] pc_o, insn_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    fmt_e        fmt_o;

    always #5 clk = ~clk;

    decode #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .insn_i(insn_i), .valid_i(valid_i),
        .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o),
        .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o),
        .fmt_o(fmt_o), .illegal_o(illegal_o)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference decode from the instruction-set rules.
    function automatic void ref_dec(input logic [31:0] w, output logic [31:0] imm,
                                    output fmt_e f, output logic ill);
        logic [31:0] t;
        t   = 32'($signed(w) >>> 20);
        imm = 32'h0;
        f   = FMT_R;
        ill = 1'b0;
        case (w[6:0])
            7'h33: f = FMT_R;
            7'h13, 7'h03, 7'h67, 7'h73: begin f = FMT_I; imm = t; end
            7'h23: begin f = FMT_S; imm = {t[31:5], w[11:7]}; end
            7'h63: begin
                f   = FMT_B;
                imm = (w[31] ? 32'hFFFFF000 : 32'h0) | (w[7] ? 32'h800 : 32'h0)
                    | {21'b0, w[30:25], 5'b0} | {27'b0, w[11:8], 1'b0};
            end
            7'h37, 7'h17: begin f = FMT_U; imm = w & 32'hFFFFF000; end
            7'h6F: begin
                f   = FMT_J;
                imm = (w[31] ? 32'hFFF00000 : 32'h0) | (w & 32'h000FF000)
                    | (w[20] ? 32'h800 : 32'h0) | {21'b0, w[30:21], 1'b0};
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Model: the stage behaves as a FIFO of capacity two; ready needs one edge out of reset.
    typedef struct packed { logic [31:0] pc; logic [31:0] insn; } item_t;
    item_t q[$];
    bit    started = 1'b0;

    always @(posedge clk) begin : model
        bit rdy, vld;
        if (!rst) begin
            q.delete();
            started = 1'b0;
        end else begin
            rdy = started && (q.size() < 2);
            vld = (q.size() > 0);
            if (flush_i) q.delete();
            else begin
                if (vld && ready_i) void'(q.pop_front());
                if (valid_i && rdy) q.push_back('{pc_i, insn_i});
            end
            started = 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] e_imm;
        fmt_e        e_fmt;
        logic        e_ill;
        if (!rst) begin
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_ready", 32'(ready_o), 32'd0);
            chk("rst_pc", pc_o, BASE);
        end else begin
            chk("ready_o", 32'(ready_o), 32'(started && (q.size() < 2)));
            chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
            if (q.size() > 0) begin
                ref_dec(q[0].insn, e_imm, e_fmt, e_ill);
                chk("pc_o", pc_o, q[0].pc);
                chk("insn_o", insn_o, q[0].insn);
                chk("opcode", 32'(opcode_o), 32'(q[0].insn[6:0]));
                chk("rd", 32'(rd_o), 32'(q[0].insn[11:7]));
                chk("funct3", 32'(funct3_o), 32'(q[0].insn[14:12]));
                chk("rs1", 32'(rs1_o), 32'(q[0].insn[19:15]));
                chk("rs2", 32'(rs2_o), 32'(q[0].insn[24:20]));
                chk("funct7", 32'(funct7_o), 32'(q[0].insn[31:25]));
                chk("imm", imm_o, e_imm);
                chk("fmt", 32'(fmt_o), 32'(e_fmt));
                chk("illegal", 32'(illegal_o), 32'(e_ill));
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                         input bit rdy, input bit fl);
        valid_i = v; pc_i = pc; insn_i = insn; ready_i = rdy; flush_i = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h33};

    initial begin
        logic [31:0] pcn, r, ins;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk("reset_pc", pc_o, 32'h01000000);
        chk("reset_insn", insn_o, 32'h00000013);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("ready_after_reset", 32'(ready_o), 32'd1);

        drive(1'b1, BASE, 32'h00500093, 1'b1, 1'b0);
        chk("addi_valid", 32'(valid_o), 32'd1);
        chk("addi_opcode", 32'(opcode_o), 32'h13);
        chk("addi_rd", 32'(rd_o), 32'd1);
        chk("addi_rs1", 32'(rs1_o), 32'd0);
        chk("addi_imm", imm_o, 32'd5);
        chk("addi_fmt", 32'(fmt_o), 32'(FMT_I));
        drive(1'b1, BASE + 4, 32'h0020A423, 1'b1, 1'b0);
        chk("sw_fmt", 32'(fmt_o), 32'(FMT_S));
        chk("sw_rs1", 32'(rs1_o), 32'd1);
        chk("sw_rs2", 32'(rs2_o), 32'd2);
        chk("sw_funct3", 32'(funct3_o), 32'd2);
        chk("sw_imm", imm_o, 32'd8);
        drive(1'b1, BASE + 8, 32'hFE000EE3, 1'b1, 1'b0);
        chk("beq_fmt", 32'(fmt_o), 32'(FMT_B));
        chk("beq_imm", imm_o, 32'hFFFFFFFC);
        drive(1'b1, BASE + 12, 32'h123452B7, 1'b1, 1'b0);
        chk("lui_fmt", 32'(fmt_o), 32'(FMT_U));
        chk("lui_rd", 32'(rd_o), 32'd5);
        chk("lui_imm", imm_o, 32'h12345000);
        drive(1'b1, BASE + 16, 32'h010000EF, 1'b1, 1'b0);
        chk("jal_fmt", 32'(fmt_o), 32'(FMT_J));
        chk("jal_rd", 32'(rd_o), 32'd1);
        chk("jal_imm", imm_o, 32'd16);
        drive(1'b1, BASE + 20, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("illegal_all_ones", 32'(illegal_o), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drained_valid", 32'(valid_o), 32'd0);

        // Backpressure: two accepts fill the stage, the third waits.
        drive(1'b1, BASE, NOP, 1'b0, 1'b0);
        drive(1'b1, BASE + 4, NOP, 1'b0, 1'b0);
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        chk("bp_pc_hold", pc_o, BASE);
        drive(1'b1, BASE + 8, NOP, 1'b0, 1'b0);
        drive(1'b1, BASE + 8, NOP, 1'b0, 1'b0);
        chk("bp_ready_low2", 32'(ready_o), 32'd0);
        chk("bp_pc_hold2", pc_o, BASE);
        drive(1'b1, BASE + 8, NOP, 1'b1, 1'b0);
        chk("bp_pc_second", pc_o, BASE + 4);
        chk("bp_ready_back", 32'(ready_o), 32'd1);
        drive(1'b1, BASE + 8, NOP, 1'b1, 1'b0);
        chk("bp_pc_third", pc_o, BASE + 8);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_empty", 32'(valid_o), 32'd0);

        // Flush while full, with a new instruction offered.
        drive(1'b1, BASE + 32'h10, NOP, 1'b0, 1'b0);
        drive(1'b1, BASE + 32'h14, NOP, 1'b0, 1'b0);
        drive(1'b1, BASE + 32'h18, NOP, 1'b0, 1'b1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_stays_empty", 32'(valid_o), 32'd0);

        // Asynchronous reset while full.
        drive(1'b1, BASE + 32'h20, NOP, 1'b0, 1'b0);
        drive(1'b1, BASE + 32'h24, NOP, 1'b0, 1'b0);
        chk("pre_areset_pc", pc_o, BASE + 32'h20);
        #2 rst = 1'b0;
        #1;
        chk("areset_valid", 32'(valid_o), 32'd0);
        chk("areset_pc", pc_o, 32'h01000000);
        chk("areset_ready", 32'(ready_o), 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Randomized traffic, checked every cycle by the compare process.
        pcn = 32'h02000000;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 9) < 9) ins = {r[31:7], ops[$urandom_range(0, 11)]};
            else ins = $urandom;
            if ($urandom_range(0, 99) < 70) begin
                valid_i = 1'b1;
                pc_i = pcn;
                pcn = pcn + 4;
            end else begin
                valid_i = 1'b0;
                pc_i = $urandom;
            end
            insn_i  = ins;
            ready_i = ($urandom_range(0, 99) < 60);
            flush_i = ($urandom_range(0, 99) < 4);
            @(posedge clk);
            @(negedge clk);
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
